// File: rtl/qr_pkg.sv
// Shared constants for the QR decoder frame-buffer datapath.
// Requester indices fix the priority slots seen by frame_read_arbiter.
package qr_pkg;

  localparam int FRAME_W     = 480;
  localparam int FRAME_H     = 480;
  localparam int FB_ADDR_W   = 20;

  localparam int REQ_CROSS   = 0;
  localparam int REQ_SAMPLE  = 1;
  localparam int REQ_OVERLAY = 2;

  localparam int NUM_FB_REQ  = 3;
  localparam int GRANT_IDX_W = 2;

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot picker with an optional lock that pins the grant to one index.
// Also used by the decoder's output arbiter.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  input  logic             lock_en,
  input  logic [PTR_W-1:0] lock_idx,
  output logic [N-1:0]     grant
);

  logic             found_s;
  logic [PTR_W-1:0] idx_s;

  // Search starts one past the last winner and wraps; a lock overrides the search.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    if (lock_en) begin
      for (int k = 0; k < N; k++) begin
        grant[k] = req[k] & (PTR_W'(k) == lock_idx);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx_s        = PTR_W'((int'(rr_ptr) + k) % N);
        grant[idx_s] = req[idx_s] & ~found_s;
        found_s      = found_s | req[idx_s];
      end
    end
  end

endmodule

// File: rtl/frame_read_arbiter.sv
// Shares the frame-buffer BRAM read port between the cross checker, sampler and overlay.
// Round-robin grant with per-requester lock; a tag pipeline routes data back to its issuer.
module frame_read_arbiter
  import qr_pkg::*;
#(
  parameter int NUM_REQ      = NUM_FB_REQ,
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      hold_in,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic                      bram_en,
  input  logic [DATA_W-1:0]         bram_dout,
  output logic [GRANT_IDX_W-1:0]    grant_idx,
  output logic                      busy
);

  logic [GRANT_IDX_W-1:0] rr_ptr_r;
  logic                   lock_valid_r;
  logic [GRANT_IDX_W-1:0] lock_idx_r;
  logic [ADDR_W-1:0]      last_addr_r;
  logic [NUM_REQ-1:0]     tag_r [READ_LATENCY];

  logic [NUM_REQ-1:0]     grant_s;
  logic                   issue_s;
  logic [GRANT_IDX_W-1:0] gidx_s;
  logic [ADDR_W-1:0]      addr_s;
  logic                   tag_any_s;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (GRANT_IDX_W)
  ) u_pick (
    .req      (req_valid),
    .rr_ptr   (rr_ptr_r),
    .lock_en  (lock_valid_r),
    .lock_idx (lock_idx_r),
    .grant    (grant_s)
  );

  // Handshake: gated by hold and by reset so nothing is accepted while rst_in is low.
  always_comb begin
    req_ready = grant_s & {NUM_REQ{~hold_in & rst_in}};
    issue_s   = |req_ready;
  end

  // One-hot AND-OR mux for the winning index and address.
  always_comb begin
    gidx_s = '0;
    addr_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gidx_s = gidx_s | (GRANT_IDX_W'(i) & {GRANT_IDX_W{req_ready[i]}});
      addr_s = addr_s | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{req_ready[i]}});
    end
  end

  // Pipeline occupancy for busy.
  always_comb begin
    tag_any_s = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      tag_any_s = tag_any_s | (|tag_r[i]);
    end
  end

  // Port drive and response routing.
  always_comb begin
    bram_en   = issue_s;
    bram_addr = issue_s ? addr_s : last_addr_r;
    rsp_valid = tag_r[READ_LATENCY-1];
    if (|tag_r[READ_LATENCY-1]) begin
      rsp_data = bram_dout;
    end else begin
      rsp_data = '0;
    end
    busy      = issue_s | tag_any_s;
    grant_idx = rr_ptr_r;
  end

  // Round-robin pointer and held BRAM address advance only on issue.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr_r    <= '0;
      last_addr_r <= '0;
    end else if (issue_s) begin
      rr_ptr_r    <= gidx_s;
      last_addr_r <= addr_s;
    end else begin
      rr_ptr_r    <= rr_ptr_r;
      last_addr_r <= last_addr_r;
    end
  end

  // Lock ownership: set/cleared on issue, and released any cycle the owner drops req_lock.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lock_valid_r <= 1'b0;
      lock_idx_r   <= '0;
    end else if (issue_s) begin
      lock_valid_r <= req_lock[gidx_s];
      lock_idx_r   <= gidx_s;
    end else if (lock_valid_r && !req_lock[lock_idx_r]) begin
      lock_valid_r <= 1'b0;
      lock_idx_r   <= lock_idx_r;
    end else begin
      lock_valid_r <= lock_valid_r;
      lock_idx_r   <= lock_idx_r;
    end
  end

  // Tag shift register matching the BRAM read latency; idle cycles push zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      tag_r[0] <= req_ready;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_frame_read_arbiter.sv
// Directed checks on a READ_LATENCY=2 arbiter plus latency-1/4 copies tracked by a scoreboard.
module tb_frame_read_arbiter;
  import qr_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [2:0]  req_valid;
  logic [2:0]  req_lock;
  logic [59:0] req_addr;
  logic        hold_in;

  logic [2:0]  rdy [3];
  logic [2:0]  rv  [3];
  logic        rd  [3];
  logic [19:0] ba  [3];
  logic        be  [3];
  logic [1:0]  gi  [3];
  logic        bz  [3];
  logic        dout[3];
  logic        pm  [3][4];
  logic [3:0]  ep  [3][4];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk_in = ~clk_in;

  frame_read_arbiter #(.READ_LATENCY(2)) u_dut_l2 (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_addr(req_addr),
    .req_lock(req_lock), .req_ready(rdy[0]), .rsp_valid(rv[0]), .rsp_data(rd[0]),
    .hold_in(hold_in), .bram_addr(ba[0]), .bram_en(be[0]), .bram_dout(dout[0]),
    .grant_idx(gi[0]), .busy(bz[0]));

  frame_read_arbiter #(.READ_LATENCY(1)) u_dut_l1 (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_addr(req_addr),
    .req_lock(req_lock), .req_ready(rdy[1]), .rsp_valid(rv[1]), .rsp_data(rd[1]),
    .hold_in(hold_in), .bram_addr(ba[1]), .bram_en(be[1]), .bram_dout(dout[1]),
    .grant_idx(gi[1]), .busy(bz[1]));

  frame_read_arbiter #(.READ_LATENCY(4)) u_dut_l4 (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_addr(req_addr),
    .req_lock(req_lock), .req_ready(rdy[2]), .rsp_valid(rv[2]), .rsp_data(rd[2]),
    .hold_in(hold_in), .bram_addr(ba[2]), .bram_en(be[2]), .bram_dout(dout[2]),
    .grant_idx(gi[2]), .busy(bz[2]));

  function automatic logic pix(input logic [19:0] a);
    return a[0] ^ a[5];
  endfunction

  function automatic int lat_of(input int n);
    return (n == 0) ? 2 : ((n == 1) ? 1 : 4);
  endfunction

  function automatic logic [19:0] sel_addr(input logic [2:0] r);
    logic [19:0] a;
    a = 20'd0;
    for (int i = 0; i < 3; i++) begin
      a = a | (req_addr[i*20 +: 20] & {20{r[i]}});
    end
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [19:0] a);
    req_addr[i*20 +: 20] = a;
  endtask

  // BRAM models: data is a fixed function of the address, delayed by each instance's latency.
  always @(posedge clk_in) begin
    for (int n = 0; n < 3; n++) begin
      pm[n][0] <= pix(ba[n]);
      for (int k = 1; k < 4; k++) pm[n][k] <= pm[n][k-1];
    end
  end
  assign dout[0] = pm[0][1];
  assign dout[1] = pm[1][0];
  assign dout[2] = pm[2][3];

  // Scoreboard: every accepted read must return to the same requester with its data after exactly L cycles.
  always @(negedge clk_in) begin
    for (int n = 0; n < 3; n++) begin
      if (!rst_in) begin
        for (int k = 0; k < 4; k++) ep[n][k] <= 4'd0;
      end else begin
        check("sb_rsp_valid", 32'(rv[n]), 32'(ep[n][lat_of(n)-1][3:1]));
        check("sb_rsp_data", 32'(rd[n]), 32'(ep[n][lat_of(n)-1][0]));
        check("sb_ready_legal", 32'(rdy[n] & ~(req_valid & {3{~hold_in}})), 32'd0);
        check("sb_ready_onehot0", 32'($onehot0(rdy[n])), 32'd1);
        check("sb_bram_en", 32'(be[n]), 32'(|rdy[n]));
        if (|rdy[n]) check("sb_bram_addr", 32'(ba[n]), 32'(sel_addr(rdy[n])));
        ep[n][0] <= {rdy[n], (|rdy[n]) ? pix(sel_addr(rdy[n])) : 1'b0};
        for (int k = 1; k < 4; k++) ep[n][k] <= ep[n][k-1];
      end
    end
  end

  int exp_g  [8] = '{1, 2, 0, 1, 2, 0, 1, 2};
  int exp_hv [4] = '{2, 4, 0, 0};
  int exp_hd [4] = '{1, 0, 0, 0};

  initial begin
    rst_in = 1'b0; req_valid = 3'd0; req_lock = 3'd0; req_addr = 60'd0; hold_in = 1'b0;
    @(negedge clk_in);
    req_valid = 3'b111;
    #1;
    check("rst_ready", 32'(rdy[0]), 32'd0);
    check("rst_bram_en", 32'(be[0]), 32'd0);
    check("rst_busy", 32'(bz[0]), 32'd0);
    check("rst_rsp_valid", 32'(rv[0]), 32'd0);
    check("rst_rsp_data", 32'(rd[0]), 32'd0);
    check("rst_grant_idx", 32'(gi[0]), 32'd0);
    req_valid = 3'd0;
    tick();
    rst_in = 1'b1;

    // single requester, back-to-back addresses
    req_valid = 3'b001; set_addr(0, 20'h00000);
    @(negedge clk_in);
    check("single_ready0", 32'(rdy[0]), 32'h1);
    check("single_en0", 32'(be[0]), 32'd1);
    check("single_addr0", 32'(ba[0]), 32'h0);
    tick(); set_addr(0, 20'h001DF);
    @(negedge clk_in);
    check("single_ready1", 32'(rdy[0]), 32'h1);
    check("single_addr1", 32'(ba[0]), 32'h1DF);
    tick(); req_valid = 3'b000;
    @(negedge clk_in);
    check("single_idle_en", 32'(be[0]), 32'd0);
    check("single_addr_held", 32'(ba[0]), 32'h1DF);
    check("single_rsp0_valid", 32'(rv[0]), 32'h1);
    check("single_rsp0_data", 32'(rd[0]), 32'd0);
    check("single_busy", 32'(bz[0]), 32'd1);
    tick();
    @(negedge clk_in);
    check("single_rsp1_valid", 32'(rv[0]), 32'h1);
    check("single_rsp1_data", 32'(rd[0]), 32'd1);
    tick();
    @(negedge clk_in);
    check("single_drained_valid", 32'(rv[0]), 32'd0);
    check("single_drained_busy", 32'(bz[0]), 32'd0);

    // contention from reset
    tick(); rst_in = 1'b0;
    tick(); rst_in = 1'b1;
    req_valid = 3'b111;
    set_addr(0, 20'h00100); set_addr(1, 20'h00101); set_addr(2, 20'h00102);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      check("rr_ready", 32'(rdy[0]), 32'(1 << exp_g[k]));
      check("rr_grant_idx", 32'(gi[0]), (k == 0) ? 32'd0 : 32'(exp_g[k-1]));
      if (k >= 2) begin
        check("rr_rsp_valid", 32'(rv[0]), 32'(1 << exp_g[k-2]));
        check("rr_rsp_data", 32'(rd[0]), (exp_g[k-2] == 1) ? 32'd1 : 32'd0);
      end
      tick();
    end
    req_valid = 3'b000;
    tick(); tick();

    // lock held by requester 1 while it idles
    req_valid = 3'b010; req_lock = 3'b010; set_addr(1, 20'h000A0);
    @(negedge clk_in);
    check("lock_issue", 32'(rdy[0]), 32'h2);
    tick();
    req_valid = 3'b101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("lock_block_ready", 32'(rdy[0]), 32'd0);
      check("lock_block_en", 32'(be[0]), 32'd0);
      check("lock_grant_idx", 32'(gi[0]), 32'd1);
      tick();
    end
    req_lock = 3'b000;
    @(negedge clk_in);
    check("lock_release_cycle", 32'(rdy[0]), 32'd0);
    tick();
    @(negedge clk_in);
    check("lock_after_first", 32'(rdy[0]), 32'h4);
    tick();
    @(negedge clk_in);
    check("lock_after_second", 32'(rdy[0]), 32'h1);
    tick();

    // hold with two reads in flight
    req_valid = 3'b010; set_addr(1, 20'h00001); set_addr(2, 20'h00000);
    @(negedge clk_in);
    check("hold_pre0", 32'(rdy[0]), 32'h2);
    tick(); req_valid = 3'b100;
    @(negedge clk_in);
    check("hold_pre1", 32'(rdy[0]), 32'h4);
    tick(); req_valid = 3'b111; hold_in = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_in);
      check("hold_en", 32'(be[0]), 32'd0);
      check("hold_ready", 32'(rdy[0]), 32'd0);
      check("hold_rsp_valid", 32'(rv[0]), 32'(exp_hv[j]));
      check("hold_rsp_data", 32'(rd[0]), 32'(exp_hd[j]));
      tick();
    end
    hold_in = 1'b0; set_addr(0, 20'h00055);
    @(negedge clk_in);
    check("hold_resume_ready", 32'(rdy[0]), 32'h1);
    check("hold_resume_en", 32'(be[0]), 32'd1);
    tick();

    // asynchronous reset one cycle after an issue
    req_valid = 3'b000;
    check("pre_rst_busy", 32'(bz[0]), 32'd1);
    rst_in = 1'b0; req_valid = 3'b111;
    #1;
    check("midrst_busy", 32'(bz[0]), 32'd0);
    check("midrst_rsp_valid", 32'(rv[0]), 32'd0);
    check("midrst_ready", 32'(rdy[0]), 32'd0);
    check("midrst_en", 32'(be[0]), 32'd0);
    check("midrst_grant_idx", 32'(gi[0]), 32'd0);
    req_valid = 3'b000;
    tick(); tick();
    rst_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check("postrst_rsp_valid", 32'(rv[0]), 32'd0);
      check("postrst_busy", 32'(bz[0]), 32'd0);
      tick();
    end

    // random traffic for the scoreboard on all three latencies
    for (int c = 0; c < 300; c++) begin
      req_valid = 3'($urandom_range(0, 7));
      req_lock  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      hold_in   = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 3; i++) set_addr(i, 20'($urandom_range(0, 20'hFFFFF)));
      tick();
    end
    req_valid = 3'd0; req_lock = 3'd0; hold_in = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    @(negedge clk_in);
    check("final_busy_l2", 32'(bz[0]), 32'd0);
    check("final_busy_l4", 32'(bz[2]), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/frame_read_arbiter.md
Name: frame_read_arbiter

Overview:
- Shares the single read port of the binarized frame-buffer BRAM (1 bit per pixel, 20-bit address, WIDTH*HEIGHT deep) between the finder-pattern cross checker, the module-grid sampler and the video overlay reader.
- Grants one read per cycle using round-robin priority, with an optional per-requester lock for raster scans.
- Tracks the fixed BRAM read latency and routes each returned pixel back to the requester that issued it.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = cross checker, 1 = sampler, 2 = overlay).
- ADDR_W, 20, BRAM address width.
- DATA_W, 1, BRAM data width.
- READ_LATENCY, 2, cycles from issue to valid bram_dout; legal range 1..4.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-low.
- req_valid  input  NUM_REQ  requester i has an address to read.
- req_addr  input  NUM_REQ x ADDR_W  packed array of per-requester addresses.
- req_lock  input  NUM_REQ  requester i asks to keep the grant after its current issue.
- req_ready  output  NUM_REQ  one-hot or zero; requester i's address is accepted this cycle.
- rsp_valid  output  NUM_REQ  one-hot or zero; the pixel for requester i is on rsp_data.
- rsp_data  output  DATA_W  returned pixel.
- hold_in  input  1  stalls all issues, e.g. during a frame-buffer swap.
- bram_addr  output  ADDR_W  read address to BRAM.
- bram_en  output  1  read enable.
- bram_dout  input  DATA_W  BRAM read data.
- grant_idx  output  2  index of the current grant holder (debug LEDs).
- busy  output  1  a read is in flight or an issue is occurring this cycle.

Behaviour:
- Reset (rst_in low, asynchronous):
  - rr_ptr = 0, lock_owner cleared, tag pipeline cleared.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, grant_idx = 0, busy = 0, bram_en = 0.
  - Reads in flight when reset asserts are dropped; no rsp_valid pulse appears after reset deasserts.
- Grant selection (combinational):
  - If lock_owner is valid, only lock_owner can be granted.
  - Otherwise the first i with req_valid[i] is granted, searching from rr_ptr+1 modulo NUM_REQ and wrapping.
  - req_ready[i] = granted[i] & req_valid[i] & ~hold_in.
- Issue: happens when any req_ready bit is high.
  - bram_addr = req_addr[granted] and bram_en = 1 in the same cycle.
  - When there is no issue, bram_en = 0 and bram_addr holds its last issued value (registered mux select).
- Round-robin update, on issue: rr_ptr <= granted index; grant_idx follows it.
- Lock, on issue:
  - If req_lock[i] = 1, lock_owner <= i.
  - If req_lock[i] = 0, lock_owner is cleared.
  - While locked, other requesters get no grant, even when the owner has req_valid = 0.
  - The lock is released only when the owner drops req_lock; the release is checked every cycle, not only on issue.
- Response pipeline: a shift register of one-hot tags, READ_LATENCY deep.
  - An issue pushes granted[]; a non-issue cycle pushes zero.
  - rsp_valid = tag at the tail; rsp_data = bram_dout when any tag bit is set, otherwise 0.
  - Issue-to-response latency is exactly READ_LATENCY cycles.
  - Throughput is one read per cycle; back-to-back issues from different requesters return in issue order.
- hold_in:
  - Blocks new issues only; the pipeline keeps draining.
  - A lock persists through hold.
- Boundary cases:
  - No requests: rr_ptr is unchanged.
  - A requester dropping req_valid without a handshake is legal.
  - req_addr is don't-care when req_valid = 0; addresses are not range-checked.
- busy = OR of all pipeline tags OR an issue this cycle.

Decomposition:
- Shared package qr_pkg:
  - localparam FRAME_W = 480, FRAME_H = 480, FB_ADDR_W = 20.
  - Requester index constants REQ_CROSS = 0, REQ_SAMPLE = 1, REQ_OVERLAY = 2.
- Sub-module rr_pick: parameterised round-robin one-hot picker (inputs: request vector, rr_ptr, lock; output: one-hot grant). It is reused by the decoder's output arbiter.

Test Plan:
- Single requester, READ_LATENCY = 2: req 0 with addr 0x00000 then 0x1DF (479) in consecutive cycles -> bram_addr shows both in consecutive cycles; rsp_valid = 3'b001 on cycles +2 and +3 with the matching BRAM data.
- Contention: all three requesters valid continuously from reset -> grants cycle 1, 2, 0, 1, 2, 0; each requester sees exactly one rsp_valid per 3 cycles; rsp_valid is never multi-hot.
- Lock: req 1 issues with req_lock = 1, then drops req_valid for 3 cycles while reqs 0 and 2 are valid -> req_ready stays 0 for 3 cycles; after req_lock drops, req 2 is granted first.
- hold_in: hold asserted for 4 cycles with 2 reads in flight -> both responses are delivered, bram_en = 0 during hold, issuing resumes the cycle after hold falls.
- Reset mid-flight: assert rst_in low one cycle after an issue -> all outputs are 0 immediately (asynchronous); after release, no stray rsp_valid.
- Parameter sweep: READ_LATENCY = 1 and 4 with random traffic against a scoreboard model -> every response matches its issued address's data, in order, with no loss or duplication.
